// File: rtl/gpu_pkg.sv
// gpu_pkg: shared frame-buffer geometry, pixel-write record and master FSM states.
package gpu_pkg;
   localparam logic [31:0] FB_BASE = 32'h0800_0000;
   localparam int unsigned H_RES   = 640;
   localparam int unsigned V_RES   = 480;
   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] color;
   } fb_write_t;
   typedef enum logic {PW_IDLE, PW_WRITE} pw_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, dout valid whenever !empty.
//   push/din write an entry (ignored while full); pop/dout read the head (ignored while empty).
//   full/empty come from a registered occupancy count.
module sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic             push_ok, pop_ok;
   assign full    = count_q == (AW+1)'(DEPTH);
   assign empty   = count_q == '0;
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + AW'(push_ok);
         rd_ptr_q <= rd_ptr_q + AW'(pop_ok);
         count_q  <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
      end
   end
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= din;
   end
endmodule

// File: rtl/pixel_write_master.sv
// pixel_write_master: queues (x,y,colour) pixel writes and issues them as Avalon-MM writes to the frame buffer.
//   pix_valid/pix_ready/pix_x/pix_y/pix_color : upstream pixel requests (transfer on valid && ready)
//   idle       : FIFO empty and no write on the bus
//   drop_count : saturating count of off-screen pixels discarded
//   master_*   : registered Avalon-MM write master
module pixel_write_master import gpu_pkg::*; #(
   parameter int          MASTER_ADDRESSWIDTH = 32,
   parameter int          DATAWIDTH           = 32,
   parameter logic [31:0] FB_BASE             = gpu_pkg::FB_BASE,
   parameter int unsigned H_RES               = gpu_pkg::H_RES,
   parameter int unsigned V_RES               = gpu_pkg::V_RES,
   parameter int          X_W                 = 10,
   parameter int          Y_W                 = 9,
   parameter int          FIFO_DEPTH          = 8
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           pix_valid,
   output logic                           pix_ready,
   input  logic [X_W-1:0]                 pix_x,
   input  logic [Y_W-1:0]                 pix_y,
   input  logic [DATAWIDTH-1:0]           pix_color,
   output logic                           idle,
   output logic [15:0]                    drop_count,
   output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
   output logic [DATAWIDTH-1:0]           master_writedata,
   output logic                           master_write,
   input  logic                           master_waitrequest
);
   pw_state_t                      state_q, state_d;
   logic [MASTER_ADDRESSWIDTH-1:0] address_q, address_d;
   logic [DATAWIDTH-1:0]           writedata_q, writedata_d;
   logic                           write_q, write_d;
   logic [15:0]                    drop_count_q, drop_count_d;
   logic                           fifo_full, fifo_empty, fifo_pop, accept, in_range;
   fb_write_t                      fifo_din, fifo_dout;
   assign pix_ready        = !fifo_full;
   assign accept           = pix_valid && !fifo_full;
   assign in_range         = (32'(pix_x) < H_RES) && (32'(pix_y) < V_RES);
   assign fifo_din.addr    = FB_BASE + ((32'(pix_y) * H_RES + 32'(pix_x)) << 2);
   assign fifo_din.color   = pix_color;
   assign drop_count_d     = (accept && !in_range && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
   assign idle             = fifo_empty && !write_q;
   assign drop_count       = drop_count_q;
   assign master_address   = address_q;
   assign master_writedata = writedata_q;
   assign master_write     = write_q;
   sync_fifo #(.WIDTH($bits(fb_write_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .push   (accept && in_range),
      .pop    (fifo_pop),
      .din    (fifo_din),
      .dout   (fifo_dout),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );
   // The bus is free to take a new beat when idle or when the current write is accepted this cycle.
   always_comb begin
      state_d     = state_q;
      address_d   = address_q;
      writedata_d = writedata_q;
      write_d     = write_q;
      fifo_pop    = 1'b0;
      if (state_q == PW_IDLE || !master_waitrequest) begin
         fifo_pop    = !fifo_empty;
         write_d     = !fifo_empty;
         state_d     = fifo_empty ? PW_IDLE : PW_WRITE;
         address_d   = fifo_empty ? address_q : fifo_dout.addr;
         writedata_d = fifo_empty ? writedata_q : fifo_dout.color;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= PW_IDLE;
         address_q    <= FB_BASE;
         writedata_q  <= '0;
         write_q      <= 1'b0;
         drop_count_q <= '0;
      end else begin
         state_q      <= state_d;
         address_q    <= address_d;
         writedata_q  <= writedata_d;
         write_q      <= write_d;
         drop_count_q <= drop_count_d;
      end
   end
endmodule

// File: tb/tb_pixel_write_master.sv
// tb_pixel_write_master: directed self-checking bench for pixel_write_master.
module tb_pixel_write_master;
   logic        clk = 1'b0;
   logic        reset_n, pix_valid, pix_ready, idle, master_write, master_waitrequest;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic [31:0] pix_color, master_address, master_writedata;
   logic [15:0] drop_count;
   int          n_tests = 0, n_fail = 0;
   int          cyc = 0, write_cycles = 0, unstable = 0, wc0, idx;
   logic        prev_hold = 1'b0, rdy;
   logic [63:0] prev_ad;
   logic [63:0] wq[$];
   int          wc[$];
   always #5 clk = ~clk;
   pixel_write_master dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .pix_valid         (pix_valid),
      .pix_ready         (pix_ready),
      .pix_x             (pix_x),
      .pix_y             (pix_y),
      .pix_color         (pix_color),
      .idle              (idle),
      .drop_count        (drop_count),
      .master_address    (master_address),
      .master_writedata  (master_writedata),
      .master_write      (master_write),
      .master_waitrequest(master_waitrequest)
   );
   // Bus monitor: records each accepted write and flags any change while stalled.
   always @(negedge clk) begin
      cyc++;
      if (master_write) write_cycles++;
      if (reset_n && prev_hold && (!master_write || {master_address, master_writedata} != prev_ad)) unstable++;
      prev_hold = master_write && master_waitrequest;
      prev_ad   = {master_address, master_writedata};
      if (master_write && !master_waitrequest) begin
         wq.push_back({master_address, master_writedata});
         wc.push_back(cyc);
      end
   end
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] fa(input int x, input int y);
      return 32'h0800_0000 + 32'((y * 640 + x) * 4);
   endfunction
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input int x, input int y, input logic [31:0] c);
      pix_x = 10'(x);
      pix_y = 9'(y);
      pix_color = c;
      pix_valid = 1'b1;
      for (int i = 0; i < 200 && !pix_ready; i++) tick(1);
      if (!pix_ready) check("send_timeout", 0, 1);
      tick(1);
      pix_valid = 1'b0;
   endtask
   task automatic wait_writes(input string tag, input int n);
      for (int i = 0; i < 100 && wq.size() < n; i++) tick(1);
      check(tag, wq.size(), n);
   endtask
   initial begin
      reset_n = 1'b0;
      pix_valid = 1'b0;
      pix_x = '0;
      pix_y = '0;
      pix_color = '0;
      master_waitrequest = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(1);
      check("rst_write", master_write, 0);
      check("rst_addr", master_address, 32'h0800_0000);
      check("rst_data", master_writedata, 0);
      check("rst_drop", drop_count, 0);
      check("rst_idle", idle, 1);
      check("rst_ready", pix_ready, 1);
      wq.delete();
      wc0 = write_cycles;
      send(0, 0, 32'h00FF_0000);
      check("t1_lat_n1", master_write, 0);
      tick(1);
      check("t1_lat_n2", master_write, 1);
      wait_writes("t1_count", 1);
      tick(2);
      check("t1_write", wq[0], {32'h0800_0000, 32'h00FF_0000});
      check("t1_one_cycle", write_cycles - wc0, 1);
      check("t1_idle", idle, 1);
      wq.delete();
      send(639, 479, 32'h0000_FF00);
      wait_writes("t2_count", 1);
      check("t2_write", wq[0], {32'h0812_BFFC, 32'h0000_FF00});
      tick(2);
      wq.delete();
      wc0 = write_cycles;
      send(640, 0, 32'h1);
      check("t3_ready_a", pix_ready, 1);
      send(0, 480, 32'h2);
      check("t3_ready_b", pix_ready, 1);
      tick(5);
      check("t3_drop", drop_count, 2);
      check("t3_no_write", write_cycles - wc0, 0);
      check("t3_no_accept", wq.size(), 0);
      wq.delete();
      wc.delete();
      unstable = 0;
      master_waitrequest = 1'b1;
      idx = 0;
      for (int k = 0; k < 20; k++) begin
         pix_valid = idx < 10;
         pix_x = 10'(idx);
         pix_y = 9'd1;
         pix_color = 32'h100 + 32'(idx);
         rdy = pix_ready;
         tick(1);
         if (pix_valid && rdy) idx++;
      end
      check("t4_accepted", idx, 9);
      check("t4_full", pix_ready, 0);
      check("t4_hold_addr", master_address, fa(0, 1));
      check("t4_hold_data", master_writedata, 32'h100);
      master_waitrequest = 1'b0;
      for (int k = 0; k < 20 && idx < 10; k++) begin
         rdy = pix_ready;
         tick(1);
         if (rdy) idx++;
      end
      pix_valid = 1'b0;
      check("t4_last_in", idx, 10);
      wait_writes("t4_count", 10);
      for (int i = 0; i < 10; i++) check("t4_order", wq[i], {fa(i, 1), 32'h100 + 32'(i)});
      check("t4_b2b", wc[9] - wc[0], 9);
      check("t4_stable", unstable, 0);
      tick(2);
      wq.delete();
      master_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) send(20 + i, 30 + i, 32'hA0 + 32'(i));
      for (int k = 0; k < 12; k++) begin
         master_waitrequest = ~master_waitrequest;
         tick(1);
      end
      master_waitrequest = 1'b0;
      wait_writes("t5_count", 4);
      tick(3);
      check("t5_no_repeat", wq.size(), 4);
      for (int i = 0; i < 4; i++) check("t5_order", wq[i], {fa(20 + i, 30 + i), 32'hA0 + 32'(i)});
      check("t5_stable", unstable, 0);
      wq.delete();
      master_waitrequest = 1'b1;
      for (int i = 0; i < 4; i++) send(i, 2, 32'hC0 + 32'(i));
      tick(1);
      check("t6_busy", master_write, 1);
      check("t6_queued", idle, 0);
      #2 reset_n = 1'b0;
      #1 check("t6_async", master_write, 0);
      tick(2);
      reset_n = 1'b1;
      master_waitrequest = 1'b0;
      tick(10);
      check("t6_no_stale", wq.size(), 0);
      check("t6_idle", idle, 1);
      check("t6_drop", drop_count, 0);
      check("t6_addr", master_address, 32'h0800_0000);
      check("t6_ready", pix_ready, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
